// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame width.
// Imported by uart_rx and reusable by the paired transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bundle from uart_rx to its consumer.
// master: receiver drives data/valid/framing_err/busy; slave: consumer reads them.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_o;
    logic                      valid_o;
    logic                      framing_err_o;
    logic                      busy_o;

    modport master (
        output data_o,
        output valid_o,
        output framing_err_o,
        output busy_o
    );

    modport slave (
        input data_o,
        input valid_o,
        input framing_err_o,
        input busy_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with selectable reset level.
// Ports: clk_in, rst_n_in (sync, active low), d_in (async), q_o (synchronised).
module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            meta <= {WIDTH{RST_VAL}};
            q_o  <= {WIDTH{RST_VAL}};
        end else begin
            meta <= d_in;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised serial line.
// Ports: clk_in, rst_n_in (sync, active low), rx_in (async line), bus (uart_rx_if.master).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 33
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rx_in,
    uart_rx_if.master     bus
);

    localparam int HALF_BAUD = CLOCKS_PER_BAUD / 2;
    localparam int CW        = $clog2(CLOCKS_PER_BAUD);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BAUD - 1);
    localparam logic [CW-1:0] BAUD_M1 = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_START = 3'(START);
    localparam logic [2:0] S_DATA  = 3'(DATA);
    localparam logic [2:0] S_STOP  = 3'(STOP);
    localparam logic [2:0] S_WAIT  = 3'(WAIT_IDLE);

    logic                      rx_s;
    logic [2:0]                state;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (rx_in),
        .q_o      (rx_s)
    );

    assign bus.busy_o = (state != S_IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state             <= S_IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            shreg             <= '0;
            bus.data_o        <= '0;
            bus.valid_o       <= 1'b0;
            bus.framing_err_o <= 1'b0;
        end else begin
            bus.valid_o       <= 1'b0;
            bus.framing_err_o <= 1'b0;
            cnt               <= cnt + CW'(1);
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        // line back high at mid-start: treat as a glitch
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt == BAUD_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt == BAUD_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            bus.data_o  <= shreg;
                            bus.valid_o <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            bus.framing_err_o <= 1'b1;
                            state             <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // hold off until the line idles so a break cannot retrigger
                    cnt <= '0;
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial-line model, scoreboard queue, monitor.
// Ports: none (top-level bench).
module tb_uart_rx;

    localparam int CPB     = 33;
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic clk_100mhz;
    logic rst_n;
    logic rx;
    longint cyc;
    int checks;
    int passes;
    logic [7:0] last_good;
    exp_t exp_q[$];

    uart_rx_if bus ();

    uart_rx #(
        .CLOCKS_PER_BAUD (CPB)
    ) dut (
        .clk_in   (clk_100mhz),
        .rst_n_in (rst_n),
        .rx_in    (rx),
        .bus      (bus)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    initial cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk_100mhz) begin
        exp_t e;
        if (bus.valid_o || bus.framing_err_o) begin
            chk("exclusive", longint'(bus.valid_o && bus.framing_err_o), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", longint'(bus.framing_err_o), longint'(e.is_err));
                chk("pulse_cycle", cyc, e.cyc);
                chk("data_o", longint'(bus.data_o), longint'(e.data));
            end
        end
    end

    task automatic hold_bauds(input int n);
        repeat (n * CPB) @(negedge clk_100mhz);
    endtask

    // Drives one frame starting on a negedge; returns with the stop bit done.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int extra_low);
        exp_t e;
        e.is_err = !stop_ok;
        e.cyc    = cyc + LATENCY;
        if (stop_ok) last_good = d;
        e.data   = last_good;
        exp_q.push_back(e);
        rx = 1'b0;
        hold_bauds(1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            hold_bauds(1);
        end
        rx = stop_ok;
        hold_bauds(1);
        if (!stop_ok) begin
            hold_bauds(extra_low);
            chk("busy_in_break", longint'(bus.busy_o), 1);
            rx = 1'b1;
            repeat (5) @(negedge clk_100mhz);
            chk("busy_after_break", longint'(bus.busy_o), 0);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk_100mhz);
    endtask

    initial begin
        logic [7:0] b;
        int waited;
        checks    = 0;
        passes    = 0;
        last_good = 8'h00;
        rx        = 1'b1;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk_100mhz);
        chk("rst_data", longint'(bus.data_o), 0);
        chk("rst_valid", longint'(bus.valid_o), 0);
        chk("rst_err", longint'(bus.framing_err_o), 0);
        chk("rst_busy", longint'(bus.busy_o), 0);
        rst_n = 1'b1;
        idle(10);

        send_frame(8'h24, 1'b1, 0);
        idle(20);

        rx = 1'b0;
        repeat (10) @(negedge clk_100mhz);
        rx = 1'b1;
        chk("glitch_busy_hi", longint'(bus.busy_o), 1);
        repeat (15) @(negedge clk_100mhz);
        chk("glitch_busy_lo", longint'(bus.busy_o), 0);
        idle(10);
        send_frame(8'h5A, 1'b1, 0);
        idle(20);

        send_frame(8'hA5, 1'b0, 2);
        idle(20);
        send_frame(8'h3C, 1'b1, 0);
        idle(20);

        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hAA, 1'b1, 0);
        idle(20);

        rx = 1'b0;
        hold_bauds(1);
        b = 8'h77;
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            hold_bauds(1);
        end
        rx = b[3];
        repeat (10) @(negedge clk_100mhz);
        chk("pre_rst_busy", longint'(bus.busy_o), 1);
        rst_n = 1'b0;
        @(negedge clk_100mhz);
        rst_n = 1'b1;
        chk("midrst_data", longint'(bus.data_o), 0);
        chk("midrst_busy", longint'(bus.busy_o), 0);
        chk("midrst_valid", longint'(bus.valid_o), 0);
        last_good = 8'h00;
        idle(400);
        send_frame(8'hFF, 1'b1, 0);
        idle(5);

        b = 8'h00; send_frame(b, 1'b1, 0);
        b = 8'hFF; send_frame(b, 1'b1, 0);
        b = 8'h80; send_frame(b, 1'b1, 0);
        b = 8'h01; send_frame(b, 1'b1, 0);
        idle(3);

        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 0);
            idle($urandom_range(0, 12));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(negedge clk_100mhz);
            waited++;
        end
        chk("drain", exp_q.size(), 0);
        idle(50);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
